// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter in front of a single-port asynchronous-read SRAM.
// One access per cycle; grants are combinational, read data is captured at the
// grant edge and presented with a one-cycle rvalid pulse on the requesting port.
// Build option: define SRAM_ARB_ROUND_ROBIN_EN for alternating grants on
// contention; otherwise port 0 has fixed priority.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  output logic                  mem_cs,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  port_e                 last_grant_q, last_grant_d;
  logic                  p0_rvalid_q, p0_rvalid_d;
  logic                  p1_rvalid_q, p1_rvalid_d;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
  logic                  gnt0, gnt1;

  // Arbitration: single requester always wins; contention resolved by build option.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (p0_req && p1_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        if (last_grant_q == PORT1) gnt0 = 1'b1;
        else                       gnt1 = 1'b1;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = p0_req;
        gnt1 = p1_req;
      end
    end
  end

  // SRAM command mux: granted port drives the bus, idle bus is all zero.
  always_comb begin
    mem_cs   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (gnt0) begin
      mem_cs   = 1'b1;
      mem_we   = p0_we;
      mem_addr = p0_addr;
      mem_din  = p0_wdata;
    end else if (gnt1) begin
      mem_cs   = 1'b1;
      mem_we   = p1_we;
      mem_addr = p1_addr;
      mem_din  = p1_wdata;
    end
  end

  // Next-state: grant history, read-data capture and one-cycle rvalid pulses.
  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt0)      last_grant_d = PORT0;
    else if (gnt1) last_grant_d = PORT1;

    p0_rvalid_d = gnt0 && !p0_we;
    p1_rvalid_d = gnt1 && !p1_we;
    p0_rdata_d  = p0_rvalid_d ? mem_dout : p0_rdata_q;
    p1_rdata_d  = p1_rvalid_d ? mem_dout : p1_rdata_q;
  end

  // State registers with synchronous reset; last_grant resets to port 1 so port 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= PORT1;
      p0_rvalid_q  <= 1'b0;
      p1_rvalid_q  <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      p0_rvalid_q  <= p0_rvalid_d;
      p1_rvalid_q  <= p1_rvalid_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  // Read-side outputs are masked while rst is high so a read granted just
  // before reset never shows up as valid, even before the reset edge lands.
  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p0_rvalid = p0_rvalid_q && !rst;
  assign p1_rvalid = p1_rvalid_q && !rst;
  assign p0_rdata  = rst ? '0 : p0_rdata_q;
  assign p1_rdata  = rst ? '0 : p1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: directed vector table plus randomized traffic
// checked against a transaction-level reference model.
module tb_sram_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam logic [DW-1:0] RD1 = 16'hA002;
`else
  localparam logic [DW-1:0] RD1 = 16'h0000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          mem_we, mem_cs;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_cs(mem_cs),
    .mem_dout(mem_dout)
  );

  // SRAM model: unwritten words read as {A0, addr}.
  logic [DW-1:0] sram [256];
  bit            written [256];
  assign mem_dout = written[mem_addr] ? sram[mem_addr] : {8'hA0, mem_addr};
  always @(posedge clk) begin
    if (mem_cs && mem_we) begin
      sram[mem_addr]    <= mem_din;
      written[mem_addr] <= 1'b1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model state (transaction level).
  bit            m_last = 1'b1;
  bit            m_rv0 = 1'b0, m_rv1 = 1'b0;
  logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
  logic [DW-1:0] ref_mem [256];
  bit            m_g0, m_g1;

  // Check current outputs against the model, then advance the model one cycle.
  task automatic model_step();
    bit eg0, eg1;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    eg0 = 1'b0; eg1 = 1'b0;
    if (!rst) begin
      if (p0_req && p1_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        if (m_last) eg0 = 1'b1; else eg1 = 1'b1;
`else
        eg0 = 1'b1;
`endif
      end else begin
        eg0 = p0_req;
        eg1 = p1_req;
      end
    end
    e_we = 1'b0; e_addr = '0; e_din = '0;
    if (eg0) begin e_we = p0_we; e_addr = p0_addr; e_din = p0_wdata; end
    if (eg1) begin e_we = p1_we; e_addr = p1_addr; e_din = p1_wdata; end
    chk("m_p0_gnt", 32'(p0_gnt), 32'(eg0));
    chk("m_p1_gnt", 32'(p1_gnt), 32'(eg1));
    chk("m_mem_cs", 32'(mem_cs), 32'(eg0 | eg1));
    chk("m_mem_we", 32'(mem_we), 32'(e_we));
    chk("m_mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("m_mem_din", 32'(mem_din), 32'(e_din));
    chk("m_p0_rvalid", 32'(p0_rvalid), 32'(m_rv0 && !rst));
    chk("m_p1_rvalid", 32'(p1_rvalid), 32'(m_rv1 && !rst));
    chk("m_p0_rdata", 32'(p0_rdata), rst ? 32'd0 : 32'(m_rd0));
    chk("m_p1_rdata", 32'(p1_rdata), rst ? 32'd0 : 32'(m_rd1));
    if (m_rv0 && m_rv1 && !rst) chk("m_rvalid_both", 32'd1, 32'd0);
    if (rst) begin
      m_last = 1'b1; m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
    end else begin
      m_rv0 = 1'b0; m_rv1 = 1'b0;
      if (eg0) begin
        m_last = 1'b0;
        if (p0_we) ref_mem[p0_addr] = p0_wdata;
        else begin m_rd0 = ref_mem[p0_addr]; m_rv0 = 1'b1; end
      end
      if (eg1) begin
        m_last = 1'b1;
        if (p1_we) ref_mem[p1_addr] = p1_wdata;
        else begin m_rd1 = ref_mem[p1_addr]; m_rv1 = 1'b1; end
      end
    end
    m_g0 = eg0; m_g1 = eg1;
  endtask

  typedef struct {
    bit rst;
    bit r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    bit r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    bit g0, g1, v0, v1; logic [DW-1:0] rd0, rd1;
  } vec_t;

  function automatic vec_t mk(bit rs, bit r0, bit w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                              bit r1, bit w1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                              bit g0, bit g1, bit v0, bit v1,
                              logic [DW-1:0] rd0, logic [DW-1:0] rd1);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  vec_t tbl [22];

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = {8'hA0, 8'(i)};

    // Each row: inputs for one cycle and outputs expected during that cycle.
    tbl[0]  = mk(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,0, 16'h0000,16'h0000);
    tbl[1]  = mk(1, 1,1,8'h33,16'h0055, 0,0,8'h00,16'h0000, 0,0,0,0, 16'h0000,16'h0000);
    tbl[2]  = mk(0, 1,1,8'h10,16'hBEEF, 0,0,8'h00,16'h0000, 1,0,0,0, 16'h0000,16'h0000);
    tbl[3]  = mk(0, 1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 1,0,0,0, 16'h0000,16'h0000);
    tbl[4]  = mk(0, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,1,0, 16'hBEEF,16'h0000);
    tbl[5]  = mk(0, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,0, 16'hBEEF,16'h0000);
    tbl[6]  = mk(1, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,0, 16'h0000,16'h0000);
    tbl[7]  = mk(0, 1,0,8'h01,16'h0000, 1,0,8'h02,16'h0000, 1,0,0,0, 16'h0000,16'h0000);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    tbl[8]  = mk(0, 1,0,8'h01,16'h0000, 1,0,8'h02,16'h0000, 0,1,1,0, 16'hA001,16'h0000);
    tbl[9]  = mk(0, 1,0,8'h01,16'h0000, 1,0,8'h02,16'h0000, 1,0,0,1, 16'hA001,16'hA002);
    tbl[10] = mk(0, 1,0,8'h01,16'h0000, 1,0,8'h02,16'h0000, 0,1,1,0, 16'hA001,16'hA002);
    tbl[11] = mk(0, 1,0,8'h20,16'h0000, 1,1,8'h20,16'h1234, 1,0,0,1, 16'hA001,16'hA002);
`else
    tbl[8]  = mk(0, 1,0,8'h01,16'h0000, 1,0,8'h02,16'h0000, 1,0,1,0, 16'hA001,16'h0000);
    tbl[9]  = mk(0, 1,0,8'h01,16'h0000, 1,0,8'h02,16'h0000, 1,0,1,0, 16'hA001,16'h0000);
    tbl[10] = mk(0, 1,0,8'h01,16'h0000, 1,0,8'h02,16'h0000, 1,0,1,0, 16'hA001,16'h0000);
    tbl[11] = mk(0, 1,0,8'h20,16'h0000, 1,1,8'h20,16'h1234, 1,0,1,0, 16'hA001,16'h0000);
`endif
    tbl[12] = mk(0, 0,0,8'h00,16'h0000, 1,1,8'h20,16'h1234, 0,1,1,0, 16'hA020,RD1);
    tbl[13] = mk(0, 1,0,8'h20,16'h0000, 0,0,8'h00,16'h0000, 1,0,0,0, 16'hA020,RD1);
    tbl[14] = mk(0, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,1,0, 16'h1234,RD1);
    tbl[15] = mk(0, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,0, 16'h1234,RD1);
    tbl[16] = mk(0, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,0, 16'h1234,RD1);
    tbl[17] = mk(0, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,0, 16'h1234,RD1);
    tbl[18] = mk(0, 1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 1,0,0,0, 16'h1234,RD1);
    tbl[19] = mk(1, 1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,0, 16'h0000,16'h0000);
    tbl[20] = mk(0, 1,0,8'h01,16'h0000, 1,0,8'h02,16'h0000, 1,0,0,0, 16'h0000,16'h0000);
    tbl[21] = mk(0, 0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,1,0, 16'hA001,16'h0000);

    // First posedge (t=5) sees rst high; drive and check from each negedge.
    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      rst = tbl[i].rst;
      p0_req = tbl[i].r0; p0_we = tbl[i].w0; p0_addr = tbl[i].a0; p0_wdata = tbl[i].d0;
      p1_req = tbl[i].r1; p1_we = tbl[i].w1; p1_addr = tbl[i].a1; p1_wdata = tbl[i].d1;
      #1;
      chk($sformatf("t%0d_p0_gnt", i), 32'(p0_gnt), 32'(tbl[i].g0));
      chk($sformatf("t%0d_p1_gnt", i), 32'(p1_gnt), 32'(tbl[i].g1));
      chk($sformatf("t%0d_p0_rvalid", i), 32'(p0_rvalid), 32'(tbl[i].v0));
      chk($sformatf("t%0d_p1_rvalid", i), 32'(p1_rvalid), 32'(tbl[i].v1));
      chk($sformatf("t%0d_p0_rdata", i), 32'(p0_rdata), 32'(tbl[i].rd0));
      chk($sformatf("t%0d_p1_rdata", i), 32'(p1_rdata), 32'(tbl[i].rd1));
      model_step();
      @(negedge clk);
    end

    // Randomized traffic: a requester keeps its request stable until granted.
    rst = 1'b0;
    p0_req = 1'b0; p1_req = 1'b0;
    m_g0 = 1'b0; m_g1 = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (!p0_req || m_g0) begin
        p0_req   = ($urandom_range(0, 3) != 0);
        p0_we    = $urandom_range(0, 1) == 1;
        p0_addr  = 8'($urandom_range(0, 15));
        p0_wdata = 16'($urandom);
      end
      if (!p1_req || m_g1) begin
        p1_req   = ($urandom_range(0, 3) != 0);
        p1_we    = $urandom_range(0, 1) == 1;
        p1_addr  = 8'($urandom_range(0, 15));
        p1_wdata = 16'($urandom);
      end
      #1;
      model_step();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
